spi_rx_deserializer: RTL

//  SPI slave receiver; the receive end of the link our SPI transmitter drives. Mode 0 only.

---
 rtl/spi_pkg.sv | 19 +
 rtl/spi_sync_edge.sv | 40 ++++
 rtl/spi_rx_deserializer.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
//==============================================================================
// Module      : spi_pkg
// Description : Shared types and constants for the SPI receive path.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package spi_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } spi_rx_state_t;

    localparam logic [1:0] SPI_MODE0 = 2'b00;

endpackage : spi_pkg

`default_nettype wire

// File: rtl/spi_sync_edge.sv
//==============================================================================
// Module      : spi_sync_edge
// Description : Multi-flop synchronizer with rise/fall detection on the synced level.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module spi_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic a_rst_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    // r_prev resets to the same level as the chain so reset release never fakes an edge
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            r_sync <= {STAGES{RESET_VAL}};
            r_prev <= RESET_VAL;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], din};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign dout = r_sync[STAGES-1];
    assign rise =  r_sync[STAGES-1] & ~r_prev;
    assign fall = ~r_sync[STAGES-1] &  r_prev;

endmodule : spi_sync_edge

`default_nettype wire

// File: rtl/spi_rx_deserializer.sv
//==============================================================================
// Module      : spi_rx_deserializer
// Description : Mode-0 SPI slave receiver, oversampled in clk_100, valid/ready out.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module spi_rx_deserializer
    import spi_pkg::*;
#(
    parameter int P_DATA_WIDTH  = 8,
    parameter int P_SYNC_STAGES = 2,
    parameter bit P_MSB_FIRST   = 1'b1
) (
    input  logic                    clk_100,
    input  logic                    a_rst_n,
    input  logic                    spi_sclk,
    input  logic                    spi_cs_n,
    input  logic                    spi_mosi,
    input  logic                    ready,
    output logic                    valid,
    output logic [P_DATA_WIDTH-1:0] data,
    output logic                    busy,
    output logic                    overrun,
    output logic                    frame_err
);

    localparam int                 c_cnt_w = $clog2(P_DATA_WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(P_DATA_WIDTH - 1);

    logic w_sclk_rise;
    logic w_cs_rise;
    logic w_cs_fall;
    logic w_mosi;
    logic w_unused_sclk_lvl;
    logic w_unused_sclk_fall;
    logic w_unused_cs_lvl;

    logic [P_SYNC_STAGES-1:0] r_mosi_sync;
    spi_rx_state_t            r_state;
    logic [c_cnt_w-1:0]       r_bit_cnt;
    logic [P_DATA_WIDTH-1:0]  r_shift;
    logic [P_DATA_WIDTH-1:0]  w_shift_next;
    logic                     r_word_done;
    logic                     r_frame_err;
    logic                     r_valid;
    logic [P_DATA_WIDTH-1:0]  r_data;
    logic                     r_overrun;

    spi_sync_edge #(
        .STAGES    (P_SYNC_STAGES),
        .RESET_VAL (1'b0)
    ) u_sclk_sync (
        .clk     (clk_100),
        .a_rst_n (a_rst_n),
        .din     (spi_sclk),
        .dout    (w_unused_sclk_lvl),
        .rise    (w_sclk_rise),
        .fall    (w_unused_sclk_fall)
    );

    spi_sync_edge #(
        .STAGES    (P_SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_cs_sync (
        .clk     (clk_100),
        .a_rst_n (a_rst_n),
        .din     (spi_cs_n),
        .dout    (w_unused_cs_lvl),
        .rise    (w_cs_rise),
        .fall    (w_cs_fall)
    );

    // Same depth as the sclk chain so mosi is read in step with the detected edge
    always_ff @(posedge clk_100 or negedge a_rst_n) begin
        if (!a_rst_n) begin
            r_mosi_sync <= '0;
        end else begin
            r_mosi_sync <= {r_mosi_sync[P_SYNC_STAGES-2:0], spi_mosi};
        end
    end

    assign w_mosi = r_mosi_sync[P_SYNC_STAGES-1];

    generate
        if (P_MSB_FIRST) begin : g_msb_first
            assign w_shift_next = {r_shift[P_DATA_WIDTH-2:0], w_mosi};
        end else begin : g_lsb_first
            assign w_shift_next = {w_mosi, r_shift[P_DATA_WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk_100 or negedge a_rst_n) begin
        if (!a_rst_n) begin
            r_state     <= IDLE;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_word_done <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_word_done <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_cs_fall) begin
                        r_state   <= SHIFT;
                        r_bit_cnt <= '0;
                        r_shift   <= '0;
                    end
                end
                SHIFT: begin
                    // Deselect wins over a coincident clock edge; that bit is dropped
                    if (w_cs_rise) begin
                        r_state     <= IDLE;
                        r_bit_cnt   <= '0;
                        r_frame_err <= (r_bit_cnt != '0);
                    end else if (w_sclk_rise) begin
                        r_shift <= w_shift_next;
                        if (r_bit_cnt == c_last) begin
                            r_bit_cnt   <= '0;
                            r_word_done <= 1'b1;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + c_cnt_w'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // r_shift is stable while r_word_done is high: the next sclk edge is several cycles away
    always_ff @(posedge clk_100 or negedge a_rst_n) begin
        if (!a_rst_n) begin
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (r_word_done) begin
                if (!r_valid || ready) begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign valid     = r_valid;
    assign data      = r_data;
    assign overrun   = r_overrun;
    assign frame_err = r_frame_err;
    assign busy      = (r_state == SHIFT);

endmodule : spi_rx_deserializer

`default_nettype wire
